// File: rtl/wrr_input_arbiter_pkg.sv
// Shared definitions for the weighted round-robin input arbiter:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package wrr_input_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WR_PKT = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/small_fifo.sv
// Small synchronous FIFO with a registered read port and a combinational
// peek at the top bits of the head entry (used for packet framing).
module small_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 2,
  parameter int PEEK_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  dout,
  output logic [PEEK_W-1:0] head,
  output logic              empty,
  output logic              nearly_full
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  full, wr_ok, rd_ok;

  assign full        = (count == (DEPTH_BITS+1)'(DEPTH));
  assign empty       = (count == '0);
  assign nearly_full = (count >= (DEPTH_BITS+1)'(DEPTH - 1));
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign head        = mem[rd_ptr][WIDTH-1 -: PEEK_W];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{DEPTH_BITS{1'b0}}, wr_ok} - {{DEPTH_BITS{1'b0}}, rd_ok};
    end
  end

endmodule

// File: rtl/wrr_input_arbiter.sv
// Weighted round-robin packet arbiter: NUM_QUEUES input FIFOs merged onto one
// output, each queue getting max(weight,1) whole packets per turn.
module wrr_input_arbiter
  import wrr_input_arbiter_pkg::*;
#(
  parameter  int DATA_WIDTH      = 64,
  parameter  int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter  int NUM_QUEUES      = 8,
  parameter  int FIFO_DEPTH_BITS = 2,
  parameter  int WEIGHT_WIDTH    = 4,
  localparam int QW              = clog2(NUM_QUEUES)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
  input  logic [NUM_QUEUES-1:0]              in_wr,
  output logic [NUM_QUEUES-1:0]              in_rdy,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weight,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [CTRL_WIDTH-1:0]              out_ctrl,
  output logic                               out_wr,
  input  logic                               out_rdy,
  output logic [QW-1:0]                      grant_q,
  output logic                               eop
);
  localparam int FW     = CTRL_WIDTH + DATA_WIDTH;
  localparam int STAGES = 2;

  logic [NUM_QUEUES-1:0][FW-1:0]           fifo_dout;
  logic [NUM_QUEUES-1:0][CTRL_WIDTH-1:0]   fifo_head;
  logic [NUM_QUEUES-1:0][WEIGHT_WIDTH-1:0] w;
  logic [NUM_QUEUES-1:0]                   empty, nearly_full, rd_en;

  state_t                  state, state_nxt;
  logic [QW-1:0]           grant_q_nxt, sel_q, cand, cur_q, rd_q_d1;
  logic [WEIGHT_WIDTH-1:0] credit, credit_nxt;
  logic                    seen_body, seen_body_nxt, any_ne, keep, rd_last;
  logic [CTRL_WIDTH-1:0]   head_ctrl;
  logic [STAGES:1]         vld_pipe, eop_pipe;

  assign w      = weight;
  assign in_rdy = ~nearly_full;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_q
    small_fifo #(
      .WIDTH(FW), .DEPTH_BITS(FIFO_DEPTH_BITS), .PEEK_W(CTRL_WIDTH)
    ) u_fifo (
      .clk, .reset,
      .din({in_ctrl[q*CTRL_WIDTH +: CTRL_WIDTH], in_data[q*DATA_WIDTH +: DATA_WIDTH]}),
      .wr_en(in_wr[q]), .rd_en(rd_en[q]),
      .dout(fifo_dout[q]), .head(fifo_head[q]),
      .empty(empty[q]), .nearly_full(nearly_full[q])
    );
  end

  // First non-empty queue after grant_q, wrapping; grant_q itself is tried last.
  always_comb begin
    sel_q  = grant_q;
    any_ne = 1'b0;
    cand   = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      cand = QW'((int'(grant_q) + i) % NUM_QUEUES);
      if (!any_ne && !empty[cand]) begin
        any_ne = 1'b1;
        sel_q  = cand;
      end
    end
  end

  assign keep      = (credit != '0) && !empty[grant_q];
  assign cur_q     = (state == IDLE && !keep) ? sel_q : grant_q;
  assign head_ctrl = fifo_head[cur_q];

  always_comb begin
    state_nxt     = state;
    grant_q_nxt   = grant_q;
    credit_nxt    = credit;
    seen_body_nxt = seen_body;
    rd_en         = '0;
    rd_last       = 1'b0;
    case (state)
      IDLE: begin
        if (!keep && any_ne) begin
          grant_q_nxt = sel_q;
          credit_nxt  = (w[sel_q] == '0) ? WEIGHT_WIDTH'(1) : w[sel_q];
        end
      end
      WR_PKT: ;
    endcase
    // The head word's ctrl is known before reading, so the last word is
    // detected at read time and nothing past the packet end is fetched.
    if (out_rdy && !empty[cur_q]) begin
      rd_en[cur_q] = 1'b1;
      if (seen_body && head_ctrl != '0) begin
        rd_last       = 1'b1;
        seen_body_nxt = 1'b0;
        state_nxt     = IDLE;
        if (credit_nxt != '0) credit_nxt = credit_nxt - WEIGHT_WIDTH'(1);
      end else begin
        seen_body_nxt = seen_body | (head_ctrl == '0);
        state_nxt     = WR_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= QW'(NUM_QUEUES - 1);
      credit    <= '0;
      seen_body <= 1'b0;
      rd_q_d1   <= '0;
      vld_pipe  <= '0;
      eop_pipe  <= '0;
      out_data  <= '0;
      out_ctrl  <= '0;
    end else begin
      state       <= state_nxt;
      grant_q     <= grant_q_nxt;
      credit      <= credit_nxt;
      seen_body   <= seen_body_nxt;
      rd_q_d1     <= cur_q;
      vld_pipe    <= {vld_pipe[STAGES-1:1], |rd_en};
      eop_pipe    <= {eop_pipe[STAGES-1:1], rd_last};
      if (vld_pipe[1]) {out_ctrl, out_data} <= fifo_dout[rd_q_d1];
    end
  end

  assign out_wr = vld_pipe[STAGES];
  assign eop    = eop_pipe[STAGES];

endmodule

// File: tb/tb_wrr_input_arbiter.sv
// Directed bench for wrr_input_arbiter: single packet, round robin, weights,
// back-pressure, idle grant hop and reset abort.
module tb_wrr_input_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] in_data;
  logic [63:0]  in_ctrl;
  logic [7:0]   in_wr, in_rdy;
  logic [31:0]  weight;
  logic [63:0]  out_data;
  logic [7:0]   out_ctrl;
  logic         out_wr, out_rdy, eop;
  logic [2:0]   grant_q;

  wrr_input_arbiter dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_wr(in_wr), .in_rdy(in_rdy), .weight(weight), .out_data(out_data),
    .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .grant_q(grant_q), .eop(eop)
  );

  always #5 clk = ~clk;

  logic [71:0] feed [8][$];
  logic [71:0] got [$];
  logic        got_eop [$];
  logic [71:0] exp_w [$];
  logic        exp_e [$];
  int checks = 0, errors = 0, viol = 0, rdy_mode = 0;
  bit rdy_ph = 1'b1;

  function automatic logic [71:0] mk_word(input int q, input int p, input int wi, input int n);
    logic [7:0] c;
    c = (wi == 0) ? 8'hFF : (wi == n - 1) ? 8'h40 : 8'h00;
    return {c, 8'(q), 8'(p), 8'(wi), 40'h5AC3960FE1};
  endfunction

  task automatic push_pkt(input int q, input int p, input int n);
    for (int i = 0; i < n; i++) feed[q].push_back(mk_word(q, p, i, n));
  endtask

  task automatic exp_pkt(input int q, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      exp_w.push_back(mk_word(q, p, i, n));
      exp_e.push_back(i == n - 1);
    end
  endtask

  // One clock: set out_rdy, record outputs, then feed upstream words honouring in_rdy.
  task automatic step();
    @(negedge clk);
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       begin out_rdy = rdy_ph; rdy_ph = !rdy_ph; end
      default: out_rdy = 1'b0;
    endcase
    if (out_wr) begin
      got.push_back({out_ctrl, out_data});
      got_eop.push_back(eop);
      if (!out_rdy) viol++;
    end else if (eop) viol++;
    for (int q = 0; q < 8; q++) begin
      if (!reset && feed[q].size() > 0 && in_rdy[q]) begin
        {in_ctrl[q*8 +: 8], in_data[q*64 +: 64]} = feed[q].pop_front();
        in_wr[q] = 1'b1;
      end else in_wr[q] = 1'b0;
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    int t = 0;
    while (got.size() < n && t < budget) begin step(); t++; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int q = 0; q < 8; q++) feed[q].delete();
    got.delete(); got_eop.delete(); exp_w.delete(); exp_e.delete();
    in_wr = '0; viol = 0; rdy_mode = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_data = '0; in_ctrl = '0; weight = 32'h11111111; out_rdy = 1'b1;
    do_reset();
    step();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL reset_out_wr got %b want 0", out_wr); end
    checks++; if (out_data !== 64'h0 || out_ctrl !== 8'h0) begin errors++; $display("FAIL reset_out_word got %h/%h want 0/0", out_ctrl, out_data); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL reset_eop got %b want 0", eop); end
    checks++; if (grant_q !== 3'd7) begin errors++; $display("FAIL reset_grant got %0d want 7", grant_q); end
    checks++; if (in_rdy !== 8'hFF) begin errors++; $display("FAIL reset_in_rdy got %h want ff", in_rdy); end
  endtask

  task automatic test_single_packet();
    int t = 0, t_first = -1;
    weight = 32'h11111111;
    do_reset();
    push_pkt(3, 0, 4); exp_pkt(3, 0, 4);
    while (got.size() < 4 && t < 40) begin
      step(); t++;
      if (t_first < 0 && got.size() > 0) t_first = t;
    end
    // write at step 1 -> rd_en in the next cycle -> out_wr two cycles later
    checks++; if (t_first !== 4) begin errors++; $display("FAIL single_latency got %0d want 4", t_first); end
    checks++; if (got.size() !== 4) begin errors++; $display("FAIL single_count got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k] || got_eop[k] !== exp_e[k]) begin
        errors++; $display("FAIL single_word%0d got %h eop %b want %h eop %b", k, got[k], got_eop[k], exp_w[k], exp_e[k]);
      end
    end
    checks++; if (grant_q !== 3'd3) begin errors++; $display("FAIL single_grant got %0d want 3", grant_q); end
  endtask

  task automatic test_round_robin();
    weight = 32'h11111111;
    do_reset();
    for (int p = 0; p < 2; p++) for (int q = 0; q < 8; q++) begin push_pkt(q, p, 3); exp_pkt(q, p, 3); end
    wait_words(48, 600);
    checks++; if (got.size() !== 48) begin errors++; $display("FAIL rr_count got %0d want 48", got.size()); end
    for (int k = 0; k < 48 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k] || got_eop[k] !== exp_e[k]) begin
        errors++; $display("FAIL rr_word%0d got %h eop %b want %h eop %b", k, got[k], got_eop[k], exp_w[k], exp_e[k]);
      end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rr_protocol got %0d stray pulses want 0", viol); end
  endtask

  task automatic test_weighted();
    int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int pc [2] = '{0, 0};
    weight = 32'h00000003;
    do_reset();
    for (int p = 0; p < 6; p++) push_pkt(0, p, 3);
    for (int p = 0; p < 2; p++) push_pkt(1, p, 3);
    for (int i = 0; i < 8; i++) begin exp_pkt(seq[i], pc[seq[i]], 3); pc[seq[i]]++; end
    wait_words(24, 400);
    checks++; if (got.size() !== 24) begin errors++; $display("FAIL wrr_count got %0d want 24", got.size()); end
    for (int k = 0; k < 24 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k] || got_eop[k] !== exp_e[k]) begin
        errors++; $display("FAIL wrr_word%0d got %h eop %b want %h eop %b", k, got[k], got_eop[k], exp_w[k], exp_e[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    weight = 32'h11111111;
    do_reset();
    push_pkt(2, 0, 6); exp_pkt(2, 0, 6);
    rdy_mode = 2;
    repeat (10) step();
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL bp_hold got %0d words want 0", got.size()); end
    rdy_mode = 1; rdy_ph = 1'b1;
    wait_words(6, 100);
    repeat (4) step();
    rdy_mode = 0;
    checks++; if (got.size() !== 6) begin errors++; $display("FAIL bp_count got %0d want 6", got.size()); end
    for (int k = 0; k < 6 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k] || got_eop[k] !== exp_e[k]) begin
        errors++; $display("FAIL bp_word%0d got %h eop %b want %h eop %b", k, got[k], got_eop[k], exp_w[k], exp_e[k]);
      end
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL bp_out_wr_when_not_ready got %0d want 0", viol); end
  endtask

  task automatic test_idle_hop();
    weight = 32'h11111111;
    do_reset();
    push_pkt(6, 0, 3);
    wait_words(3, 50);
    repeat (5) step();
    checks++; if (grant_q !== 3'd6) begin errors++; $display("FAIL idle_hold_grant got %0d want 6", grant_q); end
    got.delete(); got_eop.delete();
    push_pkt(5, 0, 3); exp_pkt(5, 0, 3);
    step();
    step();
    checks++; if (grant_q !== 3'd6) begin errors++; $display("FAIL hop_before got %0d want 6", grant_q); end
    step();
    checks++; if (grant_q !== 3'd5) begin errors++; $display("FAIL hop_after got %0d want 5", grant_q); end
    wait_words(3, 50);
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL hop_count got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k]) begin errors++; $display("FAIL hop_word%0d got %h want %h", k, got[k], exp_w[k]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    weight = 32'h11111111;
    do_reset();
    push_pkt(1, 0, 5);
    wait_words(2, 50);
    reset = 1'b1;
    feed[1].delete();
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (out_wr !== 1'b0 || eop !== 1'b0) begin errors++; $display("FAIL abort_out got wr %b eop %b want 0 0", out_wr, eop); end
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL abort_words got %0d want 2", got.size()); end
    checks++; if (in_rdy !== 8'hFF || grant_q !== 3'd7) begin errors++; $display("FAIL abort_state got rdy %h grant %0d want ff 7", in_rdy, grant_q); end
    repeat (6) step();
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL abort_residue got %0d words want 2", got.size()); end
    got.delete(); got_eop.delete();
    push_pkt(0, 7, 3); exp_pkt(0, 7, 3);
    wait_words(3, 50);
    repeat (4) step();
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL after_abort_count got %0d want 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_w[k] || got_eop[k] !== exp_e[k]) begin
        errors++; $display("FAIL after_abort_word%0d got %h eop %b want %h eop %b", k, got[k], got_eop[k], exp_w[k], exp_e[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_weighted();
    test_back_pressure();
    test_idle_hop();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_input_arbiter.md
WRR_INPUT_ARBITER -- requirements
Module: wrr_input_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: datapath word width in bits.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8: control width in bits.
REQ-003 Parameter NUM_QUEUES, default 8: number of input channels; legal values are 2..16.
REQ-004 Parameter FIFO_DEPTH_BITS, default 2: log2 of per-input FIFO depth.
REQ-005 Parameter WEIGHT_WIDTH, default 4: bits per queue weight.
REQ-006 Clock and reset: clk, reset, synchronous, active-high.
REQ-007 Port list:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- in_data  in  NUM_QUEUES*DATA_WIDTH  packed; queue q occupies slice [q*DATA_WIDTH +: DATA_WIDTH]
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  packed, same slicing
- in_wr  in  NUM_QUEUES  per-queue write strobe
- in_rdy  out  NUM_QUEUES  per-queue ready, equal to !nearly_full[q]
- weight  in  NUM_QUEUES*WEIGHT_WIDTH  packets per turn; 0 is treated as 1
- out_data  out  DATA_WIDTH  registered output word
- out_ctrl  out  CTRL_WIDTH  registered output control
- out_wr  out  1  output word valid
- out_rdy  in  1  downstream may accept a word
- grant_q  out  log2(NUM_QUEUES)  queue currently granted
- eop  out  1  one-cycle pulse when the last word of a packet is written

Function
REQ-008 Each queue SHALL have its own FIFO of depth 2**FIFO_DEPTH_BITS; nearly_full SHALL assert at depth-1 entries.
REQ-009 Packet framing: a packet is one or more header words (ctrl!=0), then body words (ctrl==0). The last word is the first word with ctrl!=0 that follows a word with ctrl==0.
REQ-010 The FSM SHALL have exactly two states, IDLE and WR_PKT.
REQ-011 IDLE, grant rule:
- if credit>0 and !empty[grant_q], keep grant_q;
- otherwise select the first non-empty queue searching circularly from grant_q+1, within a single cycle, and load credit=max(weight[q],1).
REQ-012 IDLE, start of transfer: a transfer SHALL start only when out_rdy=1 and the selected queue is non-empty. On start, assert rd_en for the selected queue and go to WR_PKT.
REQ-013 IDLE with all queues empty: hold grant_q and credit, assert no rd_en.
REQ-014 WR_PKT: for each cycle with out_rdy=1 and a FIFO word available, the FIFO word SHALL be registered to out_*. The next word is read only while !empty[grant_q].
REQ-015 Latency: out_wr SHALL assert exactly 2 clk cycles after the rd_en of that word.
REQ-016 out_rdy=0: no rd_en and no out_wr SHALL occur. Words are never lost or duplicated.
REQ-017 Source FIFO runs empty mid-packet: stall without out_wr and without changing grant_q.
REQ-018 Last word: on writing it, pulse eop, decrement credit (saturating at 0) and return to IDLE.
REQ-019 A weight change SHALL take effect only at the next credit load.
REQ-020 Writes to a full FIFO SHALL be ignored. An upstream that honours in_rdy SHALL never hit this case.
REQ-021 Fairness: with all queues backlogged, queue q SHALL receive exactly max(weight[q],1) consecutive packets per round.

Reset
REQ-022 On reset, the block SHALL set:
- state=IDLE, grant_q=NUM_QUEUES-1, credit=0
- out_wr=0, out_data=0, out_ctrl=0, eop=0
- all FIFOs empty
REQ-023 Reset asserted mid-packet SHALL abort the packet: no further words of it are output and all FIFO contents are discarded.
REQ-024 in_rdy SHALL be all-ones in the first cycle after reset deasserts.

Structure
REQ-025 The shared package SHALL hold the state encoding (IDLE=0, WR_PKT=1) and a clog2 function. Parameters stay local to the module.
REQ-026 Per-queue buffering SHALL reuse the existing small_fifo sub-module, instantiated NUM_QUEUES times in a generate loop. No other sub-module is required.

Verification
REQ-027 Reset, then one 4-word packet (ctrl FF,00,00,40) on q3 -> same 4 words on out, first out_wr 2 cycles after first rd_en; eop on the ctrl=40 word; grant_q=3.
REQ-028 All 8 queues backlogged, weights all 1 -> packet order 0,1,2,...,7,0.
REQ-029 Queues 0 and 1 backlogged, weight[0]=3, weight[1]=0 -> order 0,0,0,1,0,0,0,1.
REQ-030 out_rdy toggles 1,0,1,0 during a 6-word packet -> all 6 words delivered in order, no out_wr in any cycle with out_rdy=0.
REQ-031 Only q5 non-empty, grant_q=6 -> q5 granted in one IDLE cycle.
REQ-032 Reset asserted at word 2 of a 5-word packet -> out_wr=0 after reset; a following new packet on q0 is delivered intact.
